// File: rtl/stopwatch_digits.sv
// 4-digit BCD stopwatch (SS.hh) with start/stop, lap freeze and sticky wrap flag.
// Buttons are synchronized and edge-detected; displayed digits are registered.
module stopwatch_digits #(
   parameter int unsigned TICK_DIV = 500000,
   parameter int unsigned D3_MAX   = 5
) (
   input  logic       CLK,
   input  logic       CLEAR,
   input  logic       START,
   input  logic       LAP,
   output logic [3:0] D0,
   output logic [3:0] D1,
   output logic [3:0] D2,
   output logic [3:0] D3,
   output logic       RUNNING,
   output logic       OVF
);

   localparam int unsigned PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]   D3_TOP  = 4'(D3_MAX);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_LAP   = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;

   logic start_s1_q, start_s2_q, start_prev_q;
   logic lap_s1_q, lap_s2_q, lap_prev_q;
   logic start_pulse, lap_pulse;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   live_q, live_d;
   logic [15:0]   snap_q, snap_d;
   logic [15:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;
   logic          running_q, running_d;
   logic          counting, tick;

   // Button synchronizers and rising-edge detectors
   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         start_s1_q   <= 1'b0;
         start_s2_q   <= 1'b0;
         start_prev_q <= 1'b0;
         lap_s1_q     <= 1'b0;
         lap_s2_q     <= 1'b0;
         lap_prev_q   <= 1'b0;
      end else begin
         start_s1_q   <= START;
         start_s2_q   <= start_s1_q;
         start_prev_q <= start_s2_q;
         lap_s1_q     <= LAP;
         lap_s2_q     <= lap_s1_q;
         lap_prev_q   <= lap_s2_q;
      end
   end

   assign start_pulse = start_s2_q & ~start_prev_q;
   assign lap_pulse   = lap_s2_q & ~lap_prev_q;

   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         live_q    <= '0;
         snap_q    <= '0;
         disp_q    <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         live_q    <= live_d;
         snap_q    <= snap_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         running_q <= running_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      live_d    = live_q;
      snap_d    = snap_q;
      ovf_d     = ovf_q;
      counting  = (state_q == S_RUN) || (state_q == S_LAP);
      tick      = counting && (pre_q == PRE_MAX);

      if (counting) begin
         pre_d = tick ? '0 : PW'(pre_q + 1'b1);
      end else if (state_q == S_IDLE) begin
         pre_d = '0;
      end

      // BCD cascade; the top digit wraps at D3_TOP and raises the sticky flag
      if (tick) begin
         if (live_q[3:0] != 4'd9) begin
            live_d[3:0] = 4'(live_q[3:0] + 4'd1);
         end else begin
            live_d[3:0] = 4'd0;
            if (live_q[7:4] != 4'd9) begin
               live_d[7:4] = 4'(live_q[7:4] + 4'd1);
            end else begin
               live_d[7:4] = 4'd0;
               if (live_q[11:8] != 4'd9) begin
                  live_d[11:8] = 4'(live_q[11:8] + 4'd1);
               end else begin
                  live_d[11:8] = 4'd0;
                  if (live_q[15:12] != D3_TOP) begin
                     live_d[15:12] = 4'(live_q[15:12] + 4'd1);
                  end else begin
                     live_d[15:12] = 4'd0;
                     ovf_d         = 1'b1;
                  end
               end
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_pulse) state_d = S_RUN;
         end
         S_RUN: begin
            if (start_pulse) begin
               state_d = S_PAUSE;
            end else if (lap_pulse) begin
               state_d = S_LAP;
               snap_d  = live_q;
            end
         end
         S_LAP: begin
            if (start_pulse)    state_d = S_PAUSE;
            else if (lap_pulse) state_d = S_RUN;
         end
         S_PAUSE: begin
            if (start_pulse) begin
               state_d = S_RUN;
            end else if (lap_pulse) begin
               state_d = S_IDLE;
               live_d  = '0;
               pre_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      disp_d    = (state_d == S_LAP) ? snap_d : live_d;
      running_d = (state_d == S_RUN) || (state_d == S_LAP);
   end

   assign D0      = disp_q[3:0];
   assign D1      = disp_q[7:4];
   assign D2      = disp_q[11:8];
   assign D3      = disp_q[15:12];
   assign RUNNING = running_q;
   assign OVF     = ovf_q;

endmodule

// File: tb/tb_stopwatch_digits.sv
// Directed bench for stopwatch_digits with TICK_DIV=4, D3_MAX=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_digits;

   logic       CLK = 1'b0;
   logic       CLEAR, START, LAP;
   logic [3:0] D0, D1, D2, D3;
   logic       RUNNING, OVF;
   logic [15:0] digits;
   int checks = 0;
   int errors = 0;

   stopwatch_digits #(.TICK_DIV(4), .D3_MAX(5)) dut (
      .CLK(CLK), .CLEAR(CLEAR), .START(START), .LAP(LAP),
      .D0(D0), .D1(D1), .D2(D2), .D3(D3),
      .RUNNING(RUNNING), .OVF(OVF)
   );

   always #5 CLK = ~CLK;
   assign digits = {D3, D2, D1, D0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      CLEAR = 1'b1; START = 1'b1; LAP = 1'b0;
      cyc(2);
      chk("rst_digits", 32'(digits), 32'h0000);
      chk("rst_running", 32'(RUNNING), 32'd0);
      chk("rst_ovf", 32'(OVF), 32'd0);
      CLEAR = 1'b0; START = 1'b0;
      cyc(4);
      chk("idle_running", 32'(RUNNING), 32'd0);

      // 1-cycle START glitch: IDLE -> RUN two edges after it is sampled (edge E)
      START = 1'b1; cyc(1); START = 1'b0;
      cyc(2);
      chk("run_enter", 32'(RUNNING), 32'd1);
      chk("run_zero", 32'(digits), 32'h0000);
      cyc(39);
      chk("run_9ticks", 32'(digits), 32'h0009);
      START = 1'b1; cyc(1); START = 1'b0;
      chk("run_10ticks", 32'(digits), 32'h0010);
      chk("run_still", 32'(RUNNING), 32'd1);
      cyc(2);
      chk("pause_enter", 32'(RUNNING), 32'd0);
      chk("pause_digits", 32'(digits), 32'h0010);
      cyc(20);
      chk("pause_hold", 32'(digits), 32'h0010);

      // Resume at edge R with prescaler phase 2: first tick at R+2
      START = 1'b1; cyc(1); START = 1'b0;
      cyc(2);
      chk("resume_run", 32'(RUNNING), 32'd1);
      chk("resume_r0", 32'(digits), 32'h0010);
      cyc(1);
      chk("resume_r1", 32'(digits), 32'h0010);
      cyc(1);
      chk("resume_r2", 32'(digits), 32'h0011);

      // LAP at R+8 (live 0012); live keeps counting to 0017
      cyc(3);
      LAP = 1'b1; cyc(1); LAP = 1'b0;
      cyc(2);
      chk("lap_enter", 32'(digits), 32'h0012);
      chk("lap_running", 32'(RUNNING), 32'd1);
      cyc(18);
      chk("lap_frozen", 32'(digits), 32'h0012);
      LAP = 1'b1; cyc(1); LAP = 1'b0;
      cyc(1);
      chk("lap_frozen2", 32'(digits), 32'h0012);
      cyc(1);
      chk("lap_exit_live", 32'(digits), 32'h0017);

      // LAP entry coincident with tick at R+38: snapshot is pre-increment
      cyc(6);
      LAP = 1'b1; cyc(1); LAP = 1'b0;
      cyc(2);
      chk("lap_tick_snap", 32'(digits), 32'h0019);
      LAP = 1'b1; cyc(1); LAP = 1'b0;
      cyc(2);
      chk("lap_tick_live", 32'(digits), 32'h0020);

      // Run to 59.99 (tick at R+23954) and wrap at R+23958
      cyc(23913);
      chk("max_digits", 32'(digits), 32'h5999);
      chk("max_ovf", 32'(OVF), 32'd0);
      cyc(3);
      chk("prewrap", 32'(digits), 32'h5999);
      cyc(1);
      chk("wrap_digits", 32'(digits), 32'h0000);
      chk("wrap_ovf", 32'(OVF), 32'd1);
      START = 1'b1; cyc(1); START = 1'b0;
      cyc(2);
      chk("wrap_pause", 32'(RUNNING), 32'd0);
      chk("wrap_ovf_held", 32'(OVF), 32'd1);
      LAP = 1'b1; cyc(1); LAP = 1'b0;
      cyc(2);
      chk("lapreset_ovf", 32'(OVF), 32'd0);
      chk("lapreset_digits", 32'(digits), 32'h0000);
      chk("lapreset_running", 32'(RUNNING), 32'd0);

      // Restart from IDLE: prescaler was cleared, first tick 4 edges in (edge S+4)
      START = 1'b1; cyc(1); START = 1'b0;
      cyc(2);
      chk("restart_run", 32'(RUNNING), 32'd1);
      cyc(3);
      chk("restart_s3", 32'(digits), 32'h0000);
      cyc(1);
      chk("restart_s4", 32'(digits), 32'h0001);

      // Simultaneous START and LAP in RUN: START wins -> PAUSE
      START = 1'b1; LAP = 1'b1; cyc(1); START = 1'b0; LAP = 1'b0;
      cyc(2);
      chk("both_pause", 32'(RUNNING), 32'd0);
      chk("both_digits", 32'(digits), 32'h0001);

      // Resume with prescaler held at 3: tick on the next edge, then every 4
      START = 1'b1; cyc(1); START = 1'b0;
      cyc(2);
      chk("resume2_run", 32'(RUNNING), 32'd1);
      cyc(1);
      chk("resume2_tick", 32'(digits), 32'h0002);
      cyc(128);
      chk("pre_clear", 32'(digits), 32'h0034);
      CLEAR = 1'b1; cyc(1);
      chk("clear_digits", 32'(digits), 32'h0000);
      chk("clear_running", 32'(RUNNING), 32'd0);
      chk("clear_ovf", 32'(OVF), 32'd0);
      CLEAR = 1'b0;
      cyc(8);
      chk("clear_idle", 32'(digits), 32'h0000);
      chk("clear_idle_run", 32'(RUNNING), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
